// File: rtl/pad_pkg.sv
// Shared constants and state encoding for the SNES/NES controller poller.
package pad_pkg;

  localparam int unsigned DEF_NUM_PADS = 2;
  localparam int unsigned DEF_NUM_BITS = 16;
  localparam int unsigned DEF_CLK_DIV  = 300;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LATCH = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_DONE  = 3'd4
  } pad_state_t;

endpackage

// File: rtl/pad_tick_gen.sv
// Protocol tick counter: restarts at zero on every state entry and flags the
// last cycle of a one- or two-tick phase.
module pad_tick_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic long_tick,
  output logic last_c
);

  localparam int unsigned CNT_W = $clog2(2 * CLK_DIV);

  logic [CNT_W-1:0] cnt;

  assign last_c = run && (cnt == (long_tick ? CNT_W'(2 * CLK_DIV - 1)
                                            : CNT_W'(CLK_DIV - 1)));

  // Idle or phase end both reload, so each new phase starts counting from 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!run || last_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/snes_pad_poller.sv
// Polls NUM_PADS serial game pads on a shared latch/clock pair once per en
// rising edge and publishes the button state plus newly pressed buttons.
module snes_pad_poller
  import pad_pkg::*;
#(
  parameter int unsigned NUM_PADS = DEF_NUM_PADS,
  parameter int unsigned NUM_BITS = DEF_NUM_BITS,
  parameter int unsigned CLK_DIV  = DEF_CLK_DIV
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [NUM_PADS-1:0]          data,
  output logic                         latch,
  output logic                         pulse,
  output logic [NUM_PADS*NUM_BITS-1:0] plyr_input,
  output logic [NUM_PADS*NUM_BITS-1:0] new_press,
  output logic                         valid,
  output logic                         busy
);

  localparam int unsigned W     = NUM_PADS * NUM_BITS;
  localparam int unsigned IDX_W = $clog2(NUM_BITS);

  pad_state_t           state;
  logic [NUM_PADS-1:0]  sync1;
  logic [NUM_PADS-1:0]  sync2;
  logic                 en_q;
  logic [IDX_W-1:0]     bit_idx;
  logic [W-1:0]         shadow;
  logic                 run_c;
  logic                 long_c;
  logic                 last_c;
  logic                 start_c;

  assign run_c   = (state == ST_LATCH) || (state == ST_HIGH) || (state == ST_LOW);
  assign long_c  = (state == ST_LATCH);
  assign start_c = (state == ST_IDLE) && en && !en_q;

  pad_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk       (clk),
    .rst       (rst),
    .run       (run_c),
    .long_tick (long_c),
    .last_c    (last_c)
  );

  // Outputs are updated on the transition edge so they track the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      sync1      <= '1;
      sync2      <= '1;
      en_q       <= 1'b0;
      bit_idx    <= '0;
      shadow     <= '0;
      latch      <= 1'b0;
      pulse      <= 1'b1;
      busy       <= 1'b0;
      valid      <= 1'b0;
      plyr_input <= '0;
      new_press  <= '0;
    end else begin
      sync1 <= data;
      sync2 <= sync1;
      en_q  <= en;
      valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_c) begin
            state <= ST_LATCH;
            latch <= 1'b1;
            busy  <= 1'b1;
            pulse <= 1'b1;
          end
        end
        ST_LATCH: begin
          if (last_c) begin
            state   <= ST_HIGH;
            latch   <= 1'b0;
            bit_idx <= '0;
          end
        end
        ST_HIGH: begin
          if (last_c) begin
            // Pads drive active-low; sample all pads for the current bit at once.
            for (int p = 0; p < int'(NUM_PADS); p++) begin
              for (int k = 0; k < int'(NUM_BITS); k++) begin
                if (IDX_W'(k) == bit_idx) begin
                  shadow[p*NUM_BITS + k] <= ~sync2[p];
                end
              end
            end
            state <= ST_LOW;
            pulse <= 1'b0;
          end
        end
        ST_LOW: begin
          if (last_c) begin
            pulse <= 1'b1;
            if (bit_idx == IDX_W'(NUM_BITS - 1)) begin
              state <= ST_DONE;
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
              state   <= ST_HIGH;
            end
          end
        end
        ST_DONE: begin
          plyr_input <= shadow;
          new_press  <= shadow & ~plyr_input;
          valid      <= 1'b1;
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          latch <= 1'b0;
          pulse <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/snes_pad_poller.md
SNES_PAD_POLLER -- requirements
Module: snes_pad_poller

Interface
REQ-001 SHALL have parameter NUM_PADS, default 2, number of controller ports polled in parallel (legal range 1..4).
REQ-002 SHALL have parameter NUM_BITS, default 16, bits shifted per pad per frame (legal range 8..16; 8 = NES pad, 16 = SNES pad).
REQ-003 SHALL have parameter CLK_DIV, default 300, clk cycles per protocol tick (legal minimum 4).
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  system clock; all state on its rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 en  input  1  poll trigger (frame strobe, e.g. vsync); a rising edge requests one poll.
REQ-008 data  input  NUM_PADS  serial data from each pad, active-low (0 = button pressed), asynchronous to clk.
REQ-009 latch  output  1  shared pad latch strobe, active-high.
REQ-010 pulse  output  1  shared pad shift clock, idles high.
REQ-011 plyr_input  output  NUM_PADS*NUM_BITS  button state, 1 = pressed; pad p occupies bits [p*NUM_BITS +: NUM_BITS]; bit k = k-th bit shifted.
REQ-012 new_press  output  NUM_PADS*NUM_BITS  buttons pressed this frame and released the previous frame, same layout.
REQ-013 valid  output  1  one-cycle strobe when plyr_input/new_press update.
REQ-014 busy  output  1  high while a poll is in progress.

Function
REQ-015 SHALL pass each data bit through a two-flop synchronizer before sampling.
REQ-016 SHALL register en once; start condition = en high and registered en low, evaluated only in IDLE.
REQ-017 SHALL implement states IDLE, LATCH, HIGH, LOW, DONE.
REQ-018 IDLE: latch=0, pulse=1, busy=0; start -> LATCH on the next edge; en edges in any other state are ignored (not queued).
REQ-019 LATCH: latch=1, pulse=1, busy=1, for exactly 2*CLK_DIV cycles -> HIGH with bit index 0.
REQ-020 HIGH: pulse=1 for CLK_DIV cycles; in its last cycle SHALL store the inverted synchronized data[p] into shadow bit k of pad p for all pads simultaneously -> LOW.
REQ-021 LOW: pulse=0 for CLK_DIV cycles; if k = NUM_BITS-1 -> DONE, else k increments -> HIGH.
REQ-022 DONE (one cycle): plyr_input <= shadow, new_press <= shadow & ~old plyr_input, valid=1, pulse=1 -> IDLE.
REQ-023 Tick counter SHALL reload to zero on every state entry; width = clog2(2*CLK_DIV).
REQ-024 Latch asserts one cycle after the start edge is detected; frame length LATCH..DONE = (2 + 2*NUM_BITS)*CLK_DIV + 1 cycles.
REQ-025 plyr_input and new_press SHALL hold between DONE cycles; a partial frame SHALL never reach the outputs.
REQ-026 en held high continuously SHALL produce exactly one poll.
REQ-027 en rising in the same cycle as DONE SHALL be ignored; a rising edge sampled in IDLE on the next cycle SHALL start a new poll.

Reset
REQ-028 Reset asserted at any time, including mid-frame, SHALL force IDLE, latch=0, pulse=1, busy=0, valid=0, plyr_input=0, new_press=0, shadow=0, synchronizers=1, registered en=0, counters=0.
REQ-029 After reset release, en already high SHALL count as a rising edge (registered en resets to 0).

Structure
REQ-030 State encodings and default NUM_PADS/NUM_BITS/CLK_DIV constants SHALL live in shared package pad_pkg.
REQ-031 Tick generation SHALL be sub-module pad_tick_gen (counter with reload, emits last-cycle flag); everything else is inline.

Verification (NUM_PADS=2, NUM_BITS=16, CLK_DIV=4)
REQ-032 en rise -> latch high for 8 cycles starting 1 cycle after detect, then 16 pulse lows of 4 cycles each, valid 137 cycles after latch rise.
REQ-033 pad0 drives bit pattern 0xA5F0 pressed, pad1 0x0001 (data low when pressed) -> plyr_input = 0x0001_A5F0, new_press = 0x0001_A5F0.
REQ-034 second frame pad0 0xA5F1, pad1 0x0000 -> plyr_input = 0x0000_A5F1, new_press = 0x0000_0001.
REQ-035 en toggled during busy and held high through DONE -> no second latch pulse; next clean en rise polls normally.
REQ-036 rst asserted at bit 7 of a frame -> outputs immediately 0, pulse=1, latch=0; the next poll completes with correct data.
REQ-037 NUM_PADS=4, NUM_BITS=8 build, all pads held pressed -> plyr_input = 0xFFFF_FFFF, valid after 73 cycles from latch rise.
